// File: rtl/rvfi_imem_model.sv
// Instruction-fetch responder for formal harnesses: serves fetch words where the
// halfword at imem_addr always carries imem_data, everything else comes from fill_data.
module rvfi_imem_model #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic [31:0]     fill_data,
    input  logic            stall,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            rsp_error,
    output logic [7:0]      hit_count
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned HC_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              rsp_valid_next;
    logic [WORD_W-1:0] rsp_data_next;
    logic              rsp_error_next;
    logic              hit, hit_next;
    logic [HC_W-1:0]   hit_count_next;

    logic [XLEN-1:0]   addr_hi;
    logic              lo_match, hi_match, misaligned;

    // Address of the upper halfword wraps modulo 2^XLEN by construction.
    assign addr_hi    = req_addr + XLEN'(2);
    assign lo_match   = (req_addr == imem_addr);
    assign hi_match   = (addr_hi == imem_addr);
    assign misaligned = req_addr[0];

    assign req_ready  = resetn && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            hit       <= 1'b0;
            hit_count <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            rsp_error <= rsp_error_next;
            hit       <= hit_next;
            hit_count <= hit_count_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rsp_valid_next = rsp_valid;
        rsp_data_next  = rsp_data;
        rsp_error_next = rsp_error;
        hit_next       = hit;
        hit_count_next = hit_count;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(LATENCY);
                    if (misaligned) begin
                        rsp_data_next  = '0;
                        rsp_error_next = 1'b1;
                        hit_next       = 1'b0;
                    end else begin
                        rsp_data_next  = {hi_match ? imem_data : fill_data[31:16],
                                          lo_match ? imem_data : fill_data[15:0]};
                        rsp_error_next = 1'b0;
                        hit_next       = lo_match || hi_match;
                    end
                end
            end
            WAIT: begin
                if (!stall) begin
                    if (cnt == '0) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    if (hit && !rsp_error && (hit_count != {HC_W{1'b1}})) begin
                        hit_count_next = hit_count + HC_W'(1);
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rvfi_imem_model.sv
// Directed bench for rvfi_imem_model: one instance at LATENCY=2, one at LATENCY=0.
module tb_rvfi_imem_model;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [31:0] fill_data;
    logic [31:0] req_addr;

    logic        stall, req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_data;
    logic [7:0]  hit_count;

    logic        stall0, req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_error0;
    logic [31:0] rsp_data0;
    logic [7:0]  hit_count0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rvfi_imem_model #(.XLEN(32), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn), .imem_addr(imem_addr), .imem_data(imem_data),
        .fill_data(fill_data), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .hit_count(hit_count)
    );

    rvfi_imem_model #(.XLEN(32), .LATENCY(0)) dut0 (
        .clk(clk), .resetn(resetn), .imem_addr(imem_addr), .imem_data(imem_data),
        .fill_data(fill_data), .stall(stall0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_data(rsp_data0), .rsp_error(rsp_error0), .hit_count(hit_count0)
    );

    // Stimulus only: one fetch on the LATENCY=2 instance, returns what was seen.
    task automatic do_fetch(input logic [31:0] a, output int lat,
                            output logic [31:0] d, output logic e);
        req_addr  = a;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rsp_data;
        e = rsp_error;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_error, rsp_data, hit_count} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b err=%b data=%h hits=%0d want all 0",
                     rsp_valid, rsp_error, rsp_data, hit_count);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready, req_ready0);
        end
    endtask

    task automatic test_hit_lo();
        int lat; logic [31:0] d; logic e;
        do_fetch(32'h0000_0100, lat, d, e);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL lo_latency: got %0d want 3", lat);
        end
        checks++;
        if (d !== 32'h1234_A5A5 || e !== 1'b0) begin
            errors++; $display("FAIL lo_data: got %h err=%b want 1234a5a5 err=0", d, e);
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL lo_handshake: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        checks++;
        if (hit_count !== 8'd1) begin
            errors++; $display("FAIL lo_hits: got %0d want 1", hit_count);
        end
    endtask

    task automatic test_hit_hi_and_miss();
        int lat; logic [31:0] d; logic e;
        do_fetch(32'h0000_00FE, lat, d, e);
        checks++;
        if (d !== 32'hA5A5_5678 || e !== 1'b0) begin
            errors++; $display("FAIL hi_data: got %h err=%b want a5a55678 err=0", d, e);
        end
        checks++;
        if (hit_count !== 8'd2) begin
            errors++; $display("FAIL hi_hits: got %0d want 2", hit_count);
        end
        do_fetch(32'h0000_0200, lat, d, e);
        checks++;
        if (d !== 32'h1234_5678 || e !== 1'b0) begin
            errors++; $display("FAIL miss_data: got %h err=%b want 12345678 err=0", d, e);
        end
        checks++;
        if (hit_count !== 8'd2) begin
            errors++; $display("FAIL miss_hits: got %0d want 2", hit_count);
        end
    endtask

    task automatic test_wrap_and_misaligned();
        int lat; logic [31:0] d; logic e;
        imem_addr = 32'h0000_0000;
        do_fetch(32'hFFFF_FFFE, lat, d, e);
        checks++;
        if (d !== 32'hA5A5_5678 || e !== 1'b0) begin
            errors++; $display("FAIL wrap_data: got %h err=%b want a5a55678 err=0", d, e);
        end
        checks++;
        if (hit_count !== 8'd3) begin
            errors++; $display("FAIL wrap_hits: got %0d want 3", hit_count);
        end
        imem_addr = 32'h0000_0100;
        do_fetch(32'h0000_0101, lat, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++; $display("FAIL misaligned: got %h err=%b want 00000000 err=1", d, e);
        end
        checks++;
        if (hit_count !== 8'd3) begin
            errors++; $display("FAIL misaligned_hits: got %0d want 3", hit_count);
        end
    endtask

    task automatic test_stall_backpressure();
        int lat;
        logic [31:0] held;
        req_addr   = 32'h0000_0100;
        rsp_ready0 = 1'b0;
        req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        stall0     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall0 = 1'b0;
        lat = 3;
        while (!rsp_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL stall_latency: got %0d want 4", lat);
        end
        held = rsp_data0;
        checks++;
        if (held !== 32'h1234_A5A5) begin
            errors++; $display("FAIL stall_data: got %h want 1234a5a5", held);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid0 !== 1'b1 || rsp_data0 !== 32'h1234_A5A5 || req_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h ready=%b want 1/1234a5a5/0",
                         i, rsp_valid0, rsp_data0, req_ready0);
            end
        end
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;
        checks++;
        if (rsp_valid0 !== 1'b0 || hit_count0 !== 8'd1) begin
            errors++; $display("FAIL stall_release: valid=%b hits=%0d want 0/1", rsp_valid0, hit_count0);
        end
    endtask

    task automatic test_saturation();
        int lat; logic [31:0] d; logic e;
        for (int i = 0; i < 256; i++) begin
            do_fetch(32'h0000_0100, lat, d, e);
        end
        checks++;
        if (hit_count !== 8'd255) begin
            errors++; $display("FAIL saturation: got %0d want 255", hit_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        req_addr  = 32'h0000_0100;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn    = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_ready_low: got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0 || hit_count !== 8'd0) begin
            errors++; $display("FAIL midreset_clear: valid=%b hits=%0d want 0/0", rsp_valid, hit_count);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || hit_count !== 8'd0) begin
                errors++; $display("FAIL midreset_quiet[%0d]: valid=%b hits=%0d want 0/0",
                                   i, rsp_valid, hit_count);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        resetn     = 1'b0;
        imem_addr  = 32'h0000_0100;
        imem_data  = 16'hA5A5;
        fill_data  = 32'h1234_5678;
        req_addr   = '0;
        stall      = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        stall0     = 1'b0;
        req_valid0 = 1'b0;
        rsp_ready0 = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_hit_lo();
        test_hit_hi_and_miss();
        test_wrap_and_misaligned();
        test_stall_backpressure();
        test_saturation();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
